// File: rtl/pwm_frame_controller_pkg.sv
// Shared timing constants and arming-state encoding for the ESC PWM frame controller.
// Frame timing is in microseconds on the 1 MHz us_clk domain.
package pwm_frame_controller_pkg;

   localparam int PWM_PERIOD_US        = 20000;
   localparam int MIN_PWM_TIME_HIGH_US = 1000;
   localparam int MAX_PWM_TIME_HIGH_US = 2000;
   localparam int MAX_THROTTLE         = MAX_PWM_TIME_HIGH_US - MIN_PWM_TIME_HIGH_US;

   typedef enum logic [2:0] {
      ST_DISARMED = 3'b001,
      ST_ARMING   = 3'b010,
      ST_ARMED    = 3'b100
   } arm_state_t;

   // Ceiling that still fits the command width, so narrow builds never wrap the clamp value.
   function automatic int sat_limit(input int limit, input int width);
      int width_max;
      width_max = (2 ** width) - 1;
      return (limit > width_max) ? width_max : limit;
   endfunction

endpackage

// File: rtl/pwm_frame_counter.sv
// Shared PWM time base: frame-long period counter, saturating high-time counter,
// the frame-boundary strobe and the registered frame_start pulse.
module pwm_frame_counter
   import pwm_frame_controller_pkg::*;
#(
   parameter int HIGH_WIDTH  = 10,
   parameter int PERIOD_US   = PWM_PERIOD_US,
   parameter int MIN_HIGH_US = MIN_PWM_TIME_HIGH_US
) (
   input  logic                  us_clk,
   input  logic                  resetn,
   output logic [15:0]           period_counter,
   output logic [HIGH_WIDTH-1:0] high_counter,
   output logic                  frame_start,
   output logic                  frame_boundary
);

   localparam logic [15:0] PERIOD_END = 16'(PERIOD_US);
   localparam logic [15:0] MIN_HIGH   = 16'(MIN_HIGH_US);

   // A count of 0 only exists straight out of reset, so it also opens a frame.
   assign frame_boundary = (period_counter == 16'd0) || (period_counter == PERIOD_END);

   always_ff @(posedge us_clk or negedge resetn) begin
      if (!resetn) begin
         period_counter <= 16'd0;
         high_counter   <= '0;
         frame_start    <= 1'b0;
      end else if (frame_boundary) begin
         period_counter <= 16'd1;
         high_counter   <= '0;
         frame_start    <= 1'b1;
      end else begin
         period_counter <= period_counter + 16'd1;
         frame_start    <= 1'b0;
         if ((period_counter > MIN_HIGH) && !(&high_counter))
            high_counter <= high_counter + HIGH_WIDTH'(1);
      end
   end

endmodule

// File: rtl/pwm_frame_controller.sv
// Arming sequencer and per-frame throttle latch feeding the four ESC pwm_generator_block instances.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   DISARMED    | outputs forced to 0; waits for arm_req with all cmds at 0
//   ARMING      | counting consecutive qualifying frames toward ARM_FRAMES
//   ARMED       | clamped commands latched to the generators at every frame
module pwm_frame_controller
   import pwm_frame_controller_pkg::*;
#(
   parameter int INPUT_BIT_WIDTH = 10,
   parameter int ARM_FRAMES      = 50,
   parameter int PERIOD_US       = pwm_frame_controller_pkg::PWM_PERIOD_US,
   parameter int MIN_HIGH_US     = pwm_frame_controller_pkg::MIN_PWM_TIME_HIGH_US,
   parameter int MAX_HIGH_US     = pwm_frame_controller_pkg::MAX_PWM_TIME_HIGH_US
) (
   input  logic                       us_clk,
   input  logic                       resetn,
   input  logic [INPUT_BIT_WIDTH-1:0] motor_cmd_0,
   input  logic [INPUT_BIT_WIDTH-1:0] motor_cmd_1,
   input  logic [INPUT_BIT_WIDTH-1:0] motor_cmd_2,
   input  logic [INPUT_BIT_WIDTH-1:0] motor_cmd_3,
   input  logic                       arm_req,
   input  logic                       kill,
   output logic [15:0]                period_counter,
   output logic [INPUT_BIT_WIDTH-1:0] high_counter,
   output logic [INPUT_BIT_WIDTH-1:0] motor_val_0,
   output logic [INPUT_BIT_WIDTH-1:0] motor_val_1,
   output logic [INPUT_BIT_WIDTH-1:0] motor_val_2,
   output logic [INPUT_BIT_WIDTH-1:0] motor_val_3,
   output logic                       frame_start,
   output logic                       armed,
   output logic [2:0]                 arm_state
);

   localparam int W     = INPUT_BIT_WIDTH;
   localparam int CNT_W = $clog2(ARM_FRAMES + 1);
   localparam int CEIL  = sat_limit(MAX_HIGH_US - MIN_HIGH_US, W);

   localparam logic [W-1:0]     THROTTLE_CEIL = W'(CEIL);
   localparam logic [CNT_W-1:0] ARM_LAST      = CNT_W'(ARM_FRAMES - 1);

   logic             frame_boundary;
   logic [W-1:0]     cmd         [4];
   logic [W-1:0]     cmd_clamped [4];
   logic [W-1:0]     val         [4];
   logic             cmds_zero;
   logic             armed_at_fb;
   arm_state_t       state;
   logic [CNT_W-1:0] arm_cnt;

   pwm_frame_counter #(
      .HIGH_WIDTH  (W),
      .PERIOD_US   (PERIOD_US),
      .MIN_HIGH_US (MIN_HIGH_US)
   ) u_frame_counter (
      .us_clk         (us_clk),
      .resetn         (resetn),
      .period_counter (period_counter),
      .high_counter   (high_counter),
      .frame_start    (frame_start),
      .frame_boundary (frame_boundary)
   );

   assign cmd[0] = motor_cmd_0;
   assign cmd[1] = motor_cmd_1;
   assign cmd[2] = motor_cmd_2;
   assign cmd[3] = motor_cmd_3;

   assign motor_val_0 = val[0];
   assign motor_val_1 = val[1];
   assign motor_val_2 = val[2];
   assign motor_val_3 = val[3];

   assign arm_state = state;

   always_comb begin
      cmds_zero = 1'b1;
      for (int n = 0; n < 4; n++) begin
         cmd_clamped[n] = (cmd[n] > THROTTLE_CEIL) ? THROTTLE_CEIL : cmd[n];
         if (cmd[n] != '0)
            cmds_zero = 1'b0;
      end
   end

   // Gating seen by the latch at this boundary, so the frame that completes arming already passes cmds.
   assign armed_at_fb = ((state == ST_ARMED) && arm_req) ||
                        ((state == ST_ARMING) && arm_req && cmds_zero && (arm_cnt == ARM_LAST));

   always_ff @(posedge us_clk or negedge resetn) begin
      if (!resetn) begin
         state   <= ST_DISARMED;
         arm_cnt <= '0;
         armed   <= 1'b0;
         for (int n = 0; n < 4; n++)
            val[n] <= '0;
      end else if (kill) begin
         state <= ST_DISARMED;
         armed <= 1'b0;
         for (int n = 0; n < 4; n++)
            val[n] <= '0;
      end else if (frame_boundary) begin
         case (state)
            ST_DISARMED: begin
               if (arm_req && cmds_zero) begin
                  state   <= ST_ARMING;
                  arm_cnt <= '0;
               end
            end
            ST_ARMING: begin
               if (!arm_req || !cmds_zero)
                  state <= ST_DISARMED;
               else if (arm_cnt == ARM_LAST)
                  state <= ST_ARMED;
               else
                  arm_cnt <= arm_cnt + CNT_W'(1);
            end
            ST_ARMED: begin
               if (!arm_req)
                  state <= ST_DISARMED;
            end
            default: state <= ST_DISARMED;
         endcase
         armed <= armed_at_fb;
         for (int n = 0; n < 4; n++)
            val[n] <= armed_at_fb ? cmd_clamped[n] : '0;
      end
   end

endmodule

// File: tb/tb_pwm_frame_controller.sv
// Bench for pwm_frame_controller with a shortened frame (1200 us, min 100 us, max 1100 us)
// and ARM_FRAMES = 4, so full arming and saturation sequences fit in a short run.
module tb_pwm_frame_controller;

   localparam int W    = 10;
   localparam int AF   = 4;
   localparam int P    = 1200;
   localparam int MINH = 100;
   localparam int MAXH = 1100;
   localparam int CEIL = MAXH - MINH;
   localparam int HMAX = (2 ** W) - 1;

   logic         us_clk = 1'b0;
   logic         resetn;
   logic [W-1:0] cmd_v [4];
   logic         arm_req;
   logic         kill;
   logic [15:0]  period_counter;
   logic [W-1:0] high_counter;
   logic [W-1:0] motor_val_0, motor_val_1, motor_val_2, motor_val_3;
   logic         frame_start;
   logic         armed;
   logic [2:0]   arm_state;

   int checks;
   int errors;

   int m_t;
   int m_state;
   int m_frames;
   int m_val [4];

   typedef struct {
      int cmd [4];
      int exp [4];
   } vec_t;

   vec_t vecs [4];
   int   prev_exp [4];

   always #5 us_clk = ~us_clk;

   pwm_frame_controller #(
      .INPUT_BIT_WIDTH (W),
      .ARM_FRAMES      (AF),
      .PERIOD_US       (P),
      .MIN_HIGH_US     (MINH),
      .MAX_HIGH_US     (MAXH)
   ) dut (
      .us_clk         (us_clk),
      .resetn         (resetn),
      .motor_cmd_0    (cmd_v[0]),
      .motor_cmd_1    (cmd_v[1]),
      .motor_cmd_2    (cmd_v[2]),
      .motor_cmd_3    (cmd_v[3]),
      .arm_req        (arm_req),
      .kill           (kill),
      .period_counter (period_counter),
      .high_counter   (high_counter),
      .motor_val_0    (motor_val_0),
      .motor_val_1    (motor_val_1),
      .motor_val_2    (motor_val_2),
      .motor_val_3    (motor_val_3),
      .frame_start    (frame_start),
      .armed          (armed),
      .arm_state      (arm_state)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference time base: pure arithmetic on the number of edges since reset release.
   function automatic int m_pc();
      return (m_t == 0) ? 0 : ((m_t - 1) % P) + 1;
   endfunction

   function automatic int m_hc();
      int pc;
      pc = m_pc();
      if (pc > MINH + 1)
         return ((pc - MINH - 1) > HMAX) ? HMAX : (pc - MINH - 1);
      return 0;
   endfunction

   function automatic int clampv(input int c);
      return (c > CEIL) ? CEIL : c;
   endfunction

   task automatic model_reset();
      m_t      = 0;
      m_state  = 0;
      m_frames = 0;
      for (int n = 0; n < 4; n++) m_val[n] = 0;
   endtask

   // Applies the arming rules for one clock edge using the inputs currently driven.
   task automatic model_edge();
      int  pc;
      bit  fb;
      bit  zero;
      pc   = m_pc();
      fb   = (pc == 0) || (pc == P);
      zero = (cmd_v[0] == 0) && (cmd_v[1] == 0) && (cmd_v[2] == 0) && (cmd_v[3] == 0);
      if (kill) begin
         m_state = 0;
         for (int n = 0; n < 4; n++) m_val[n] = 0;
      end else if (fb) begin
         if (m_state == 0) begin
            if (arm_req && zero) begin
               m_state  = 1;
               m_frames = 0;
            end
         end else if (m_state == 1) begin
            if (!arm_req || !zero) m_state = 0;
            else begin
               m_frames++;
               if (m_frames == AF) m_state = 2;
            end
         end else if (!arm_req) begin
            m_state = 0;
         end
         for (int n = 0; n < 4; n++) m_val[n] = (m_state == 2) ? clampv(int'(cmd_v[n])) : 0;
      end
      m_t++;
   endtask

   task automatic check_all();
      chk("period_counter", int'(period_counter), m_pc());
      chk("high_counter", int'(high_counter), m_hc());
      chk("frame_start", int'(frame_start), (m_pc() == 1) ? 1 : 0);
      chk("armed", int'(armed), (m_state == 2) ? 1 : 0);
      chk("arm_state", int'(arm_state), 1 << m_state);
      chk("motor_val_0", int'(motor_val_0), m_val[0]);
      chk("motor_val_1", int'(motor_val_1), m_val[1]);
      chk("motor_val_2", int'(motor_val_2), m_val[2]);
      chk("motor_val_3", int'(motor_val_3), m_val[3]);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_period_counter"}, int'(period_counter), 0);
      chk({tag, "_high_counter"}, int'(high_counter), 0);
      chk({tag, "_frame_start"}, int'(frame_start), 0);
      chk({tag, "_armed"}, int'(armed), 0);
      chk({tag, "_arm_state"}, int'(arm_state), 1);
      chk({tag, "_val0"}, int'(motor_val_0), 0);
      chk({tag, "_val1"}, int'(motor_val_1), 0);
      chk({tag, "_val2"}, int'(motor_val_2), 0);
      chk({tag, "_val3"}, int'(motor_val_3), 0);
   endtask

   task automatic check_vals(input string tag, input int e0, input int e1, input int e2, input int e3);
      chk({tag, "_val0"}, int'(motor_val_0), e0);
      chk({tag, "_val1"}, int'(motor_val_1), e1);
      chk({tag, "_val2"}, int'(motor_val_2), e2);
      chk({tag, "_val3"}, int'(motor_val_3), e3);
   endtask

   task automatic tick();
      model_edge();
      @(posedge us_clk);
      #1;
      check_all();
   endtask

   task automatic run_to_pc(input int target);
      for (int i = 0; i < P + 2 && m_pc() != target; i++) tick();
   endtask

   task automatic next_frame();
      tick();
      run_to_pc(1);
   endtask

   task automatic set_cmds(input int c0, input int c1, input int c2, input int c3);
      cmd_v[0] = W'(c0);
      cmd_v[1] = W'(c1);
      cmd_v[2] = W'(c2);
      cmd_v[3] = W'(c3);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      resetn  = 1'b0;
      arm_req = 1'b0;
      kill    = 1'b0;
      set_cmds(0, 0, 0, 0);
      model_reset();

      vecs[0].cmd = '{0, 500, 1000, 1023};  vecs[0].exp = '{0, 500, 1000, 1000};
      vecs[1].cmd = '{1, 999, 1001, 250};   vecs[1].exp = '{1, 999, 1000, 250};
      vecs[2].cmd = '{1022, 0, 64, 1000};   vecs[2].exp = '{1000, 0, 64, 1000};
      vecs[3].cmd = '{700, 700, 700, 700};  vecs[3].exp = '{700, 700, 700, 700};

      #22;
      check_reset_values("reset");
      @(negedge us_clk);
      resetn = 1'b1;

      // Two full frames plus the first edge of the third.
      for (int i = 0; i < 2 * P + 1; i++) begin
         tick();
         if (m_pc() == MINH + 1) chk("hc_at_min_plus1", int'(high_counter), 0);
         if (m_pc() == MINH + 2) chk("hc_first_count", int'(high_counter), 1);
         if (m_pc() == P - 1)    chk("hc_saturated", int'(high_counter), HMAX);
      end
      chk("wrap_pc", int'(period_counter), 1);
      chk("wrap_frame_start", int'(frame_start), 1);

      // Arming from DISARMED with all commands at zero.
      arm_req = 1'b1;
      next_frame();
      chk("arming_entered", int'(arm_state), 2);
      for (int f = 1; f < AF; f++) begin
         next_frame();
         chk("still_arming", int'(arm_state), 2);
      end
      next_frame();
      chk("armed_state", int'(arm_state), 4);
      chk("armed_flag", int'(armed), 1);

      // Aborted arm: a nonzero command while counting frames.
      arm_req = 1'b0;
      next_frame();
      chk("disarm_before_abort", int'(arm_state), 1);
      arm_req = 1'b1;
      next_frame();
      next_frame();
      next_frame();
      chk("abort_pre_arming", int'(arm_state), 2);
      run_to_pc(P / 2);
      cmd_v[2] = W'(5);
      tick();
      chk("abort_midframe_state", int'(arm_state), 2);
      next_frame();
      chk("abort_state", int'(arm_state), 1);
      check_vals("abort", 0, 0, 0, 0);
      cmd_v[2] = '0;

      // Arm again, then latch/clamp table.
      for (int f = 0; f < AF + 1; f++) next_frame();
      chk("rearmed", int'(armed), 1);
      for (int n = 0; n < 4; n++) prev_exp[n] = 0;
      for (int v = 0; v < 4; v++) begin
         run_to_pc(P / 4);
         set_cmds(vecs[v].cmd[0], vecs[v].cmd[1], vecs[v].cmd[2], vecs[v].cmd[3]);
         tick();
         check_vals("latch_frozen", prev_exp[0], prev_exp[1], prev_exp[2], prev_exp[3]);
         next_frame();
         check_vals("latch_clamp", vecs[v].exp[0], vecs[v].exp[1], vecs[v].exp[2], vecs[v].exp[3]);
         for (int n = 0; n < 4; n++) prev_exp[n] = vecs[v].exp[n];
      end

      // One-cycle kill mid-frame while armed at 700.
      run_to_pc(150);
      kill = 1'b1;
      tick();
      kill = 1'b0;
      check_vals("kill", 0, 0, 0, 0);
      chk("kill_state", int'(arm_state), 1);
      chk("kill_pc", int'(period_counter), 151);
      tick();
      chk("kill_pc_continues", int'(period_counter), 152);

      // Disarm by dropping arm_req, then reset mid-frame.
      set_cmds(0, 0, 0, 0);
      for (int f = 0; f < AF + 1; f++) next_frame();
      chk("armed_before_disarm", int'(armed), 1);
      set_cmds(300, 300, 300, 300);
      next_frame();
      check_vals("armed_300", 300, 300, 300, 300);
      run_to_pc(P / 3);
      arm_req = 1'b0;
      tick();
      chk("disarm_waits_fb", int'(armed), 1);
      next_frame();
      chk("disarm_state", int'(arm_state), 1);
      check_vals("disarm", 0, 0, 0, 0);
      run_to_pc(720);
      #2;
      resetn = 1'b0;
      #1;
      check_reset_values("midframe_reset");
      model_reset();
      @(negedge us_clk);
      resetn = 1'b1;
      for (int i = 0; i < 40; i++) tick();

      // Randomized frames against the reference model.
      arm_req = 1'b1;
      set_cmds(0, 0, 0, 0);
      for (int f = 0; f < 14; f++) begin
         if (f >= AF + 2) begin
            set_cmds($urandom_range(0, HMAX), $urandom_range(0, HMAX),
                     $urandom_range(0, HMAX), $urandom_range(0, HMAX));
            arm_req = ($urandom_range(0, 7) != 0);
         end
         for (int c = 0; c < P; c++) begin
            kill = ($urandom_range(0, 2999) == 0);
            if (f >= AF + 2 && $urandom_range(0, 199) == 0)
               cmd_v[$urandom_range(0, 3)] = W'($urandom_range(0, HMAX));
            tick();
         end
         kill = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
